// File: rtl/round_sequencer_if.sv
// Signal bundle between the betting-round FSM and its surroundings (buttons,
// judge, balance block, display).
interface round_sequencer_if;
    // Handshake: btn_* are single-cycle pulses with no ready; each is consumed
    // on the rising edge where it is high. win_in and current_money are levels,
    // sampled whenever the FSM needs them.
    logic        btn_ok;
    logic        btn_back;
    logic        btn_inc;
    logic        btn_dec;
    logic        win_in;
    logic [15:0] current_money;
    logic [3:0]  state;
    logic [15:0] bet_amount;
    logic [2:0]  bet_count;
    logic        win_flag;
    logic        spin_en;

    modport master (
        output btn_ok, btn_back, btn_inc, btn_dec, win_in, current_money,
        input  state, bet_amount, bet_count, win_flag, spin_en
    );

    modport slave (
        input  btn_ok, btn_back, btn_inc, btn_dec, win_in, current_money,
        output state, bet_amount, bet_count, win_flag, spin_en
    );
endinterface

// File: rtl/round_sequencer.sv
// Betting-round FSM: collects bet amount/count, validates against balance,
// sequences spin -> stop -> update -> show, and latches the win result.
module round_sequencer #(
    parameter int unsigned AMT_STEP      = 10,
    parameter int unsigned REJECT_CYCLES = 50_000_000,
    parameter int unsigned SHOW_CYCLES   = 100_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    round_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_INPUT_AMOUNT = 4'd1,
        S_INPUT_COUNT  = 4'd2,
        S_CONFIRM      = 4'd3,
        S_REJECT       = 4'd4,
        S_SPIN         = 4'd5,
        S_STOP_RESULT  = 4'd8,
        S_UPDATE_MONEY = 4'd9,
        S_SHOW_RESULT  = 4'd10,
        S_GAME_OVER    = 4'd11
    } state_e;

    localparam logic [31:0] REJECT_LAST = 32'(REJECT_CYCLES - 1);
    localparam logic [31:0] SHOW_LAST   = 32'(SHOW_CYCLES - 1);
    localparam logic [16:0] STEP17      = 17'(AMT_STEP);
    localparam logic [15:0] STEP16      = 16'(AMT_STEP);

    state_e      state_q, state_d;
    logic [15:0] amt_q, amt_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        win_q, win_d;
    logic        spin_q;
    logic        upd_q, upd_d;
    logic [31:0] dwell_q, dwell_d;

    logic        ok, back, inc, dec;
    logic [16:0] amt_sum;

    // Only the highest-priority pulse in a cycle is allowed to act.
    assign ok      = bus.btn_ok;
    assign back    = bus.btn_back & ~bus.btn_ok;
    assign inc     = bus.btn_inc  & ~bus.btn_ok & ~bus.btn_back;
    assign dec     = bus.btn_dec  & ~bus.btn_ok & ~bus.btn_back & ~bus.btn_inc;
    assign amt_sum = {1'b0, amt_q} + STEP17;

    always_comb begin
        state_d = state_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: if (ok) state_d = S_INPUT_AMOUNT;
            S_INPUT_AMOUNT: begin
                if (ok)        state_d = S_INPUT_COUNT;
                else if (back) state_d = S_IDLE;
                else if (inc)  amt_d = (amt_sum > {1'b0, bus.current_money}) ?
                                       bus.current_money : amt_sum[15:0];
                else if (dec)  amt_d = (amt_q >= STEP16) ? amt_q - STEP16 : 16'd0;
            end
            S_INPUT_COUNT: begin
                if (ok)        state_d = S_CONFIRM;
                else if (back) state_d = S_INPUT_AMOUNT;
                else if (inc)  cnt_d = (cnt_q >= 3'd4) ? 3'd1 : cnt_q + 3'd1;
                else if (dec)  cnt_d = (cnt_q <= 3'd1) ? 3'd4 : cnt_q - 3'd1;
            end
            S_CONFIRM: begin
                if (amt_q == 16'd0 || amt_q > bus.current_money) state_d = S_REJECT;
                else                                             state_d = S_SPIN;
            end
            S_REJECT: begin
                if (dwell_q == REJECT_LAST) begin
                    state_d = S_INPUT_AMOUNT;
                    amt_d   = 16'd0;
                end
            end
            S_SPIN: if (ok) state_d = S_STOP_RESULT;
            S_STOP_RESULT: begin
                win_d   = bus.win_in;
                state_d = S_UPDATE_MONEY;
            end
            // Second cycle gives the balance block time to settle current_money.
            S_UPDATE_MONEY: if (upd_q) state_d = S_SHOW_RESULT;
            S_SHOW_RESULT: begin
                if (dwell_q == SHOW_LAST) begin
                    if (bus.current_money == 16'd0) begin
                        state_d = S_GAME_OVER;
                    end else begin
                        state_d = S_IDLE;
                        amt_d   = 16'd0;
                        cnt_d   = 3'd1;
                    end
                end
            end
            S_GAME_OVER: state_d = S_GAME_OVER;
            default: state_d = S_IDLE;
        endcase

        upd_d = (state_q == S_UPDATE_MONEY) && (state_d == S_UPDATE_MONEY);
        if (state_d != state_q)
            dwell_d = 32'd0;
        else if (state_q == S_REJECT || state_q == S_SHOW_RESULT)
            dwell_d = dwell_q + 32'd1;
        else
            dwell_d = 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            amt_q   <= 16'd0;
            cnt_q   <= 3'd1;
            win_q   <= 1'b0;
            spin_q  <= 1'b0;
            upd_q   <= 1'b0;
            dwell_q <= 32'd0;
        end else begin
            state_q <= state_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            spin_q  <= (state_d == S_SPIN);
            upd_q   <= upd_d;
            dwell_q <= dwell_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.bet_amount = amt_q;
    assign bus.bet_count  = cnt_q;
    assign bus.win_flag   = win_q;
    assign bus.spin_en    = spin_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with shortened dwell times
// (REJECT_CYCLES=5, SHOW_CYCLES=4); expected values are hand-computed.
module tb_round_sequencer;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    round_sequencer_if bus ();

    round_sequencer #(
        .AMT_STEP      (10),
        .REJECT_CYCLES (5),
        .SHOW_CYCLES   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One-cycle pulse presented at a negedge, acted on at the following posedge.
    task automatic pulse(input logic ok, input logic back, input logic inc, input logic dec);
        bus.btn_ok   = ok;
        bus.btn_back = back;
        bus.btn_inc  = inc;
        bus.btn_dec  = dec;
        @(negedge clk);
        bus.btn_ok   = 1'b0;
        bus.btn_back = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
    endtask

    task automatic press_ok();   pulse(1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic press_back(); pulse(1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic press_inc();  pulse(1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic press_dec();  pulse(1'b0, 1'b0, 1'b0, 1'b1); endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"}, 32'(bus.state), 0);
        check_eq({tag, "_amt"},   32'(bus.bet_amount), 0);
        check_eq({tag, "_cnt"},   32'(bus.bet_count), 1);
        check_eq({tag, "_win"},   32'(bus.win_flag), 0);
        check_eq({tag, "_spin"},  32'(bus.spin_en), 0);
    endtask

    logic [15:0] inc_exp[4];
    logic [15:0] dec_exp[4];

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        bus.btn_ok    = 1'b0;
        bus.btn_back  = 1'b0;
        bus.btn_inc   = 1'b0;
        bus.btn_dec   = 1'b0;
        bus.win_in    = 1'b0;
        bus.current_money = 16'd100;
        rst_n = 1'b0;
        tick(2);
        check_reset_values("reset");
        rst_n = 1'b1;
        tick(1);

        // Basic round up to SPIN: amount 30, count 2
        press_ok();
        check_eq("t1_amount_state", 32'(bus.state), 1);
        press_inc(); press_inc(); press_inc();
        check_eq("t1_amt30", 32'(bus.bet_amount), 30);
        press_ok();
        check_eq("t1_count_state", 32'(bus.state), 2);
        press_inc();
        check_eq("t1_cnt2", 32'(bus.bet_count), 2);
        press_ok();
        check_eq("t1_confirm_state", 32'(bus.state), 3);
        check_eq("t1_spin_off_confirm", 32'(bus.spin_en), 0);
        tick(1);
        check_eq("t1_spin_state", 32'(bus.state), 5);
        check_eq("t1_spin_en", 32'(bus.spin_en), 1);
        check_eq("t1_amt_spin", 32'(bus.bet_amount), 30);
        check_eq("t1_cnt_spin", 32'(bus.bet_count), 2);

        // Winning stop, update, show, back to IDLE
        bus.win_in = 1'b1;
        press_ok();
        check_eq("t4_stop_state", 32'(bus.state), 8);
        check_eq("t4_spin_off", 32'(bus.spin_en), 0);
        tick(1);
        bus.win_in = 1'b0;
        check_eq("t4_upd1_state", 32'(bus.state), 9);
        check_eq("t4_win_flag", 32'(bus.win_flag), 1);
        tick(1);
        check_eq("t4_upd2_state", 32'(bus.state), 9);
        bus.current_money = 16'd130;
        tick(1);
        check_eq("t4_show_state", 32'(bus.state), 10);
        check_eq("t4_amt_show", 32'(bus.bet_amount), 30);
        tick(3);
        check_eq("t4_show_last", 32'(bus.state), 10);
        tick(1);
        check_eq("t4_idle_state", 32'(bus.state), 0);
        check_eq("t4_amt_cleared", 32'(bus.bet_amount), 0);
        check_eq("t4_cnt_cleared", 32'(bus.bet_count), 1);
        check_eq("t4_win_held", 32'(bus.win_flag), 1);

        // Saturating increment / clamped decrement with balance 25
        bus.current_money = 16'd25;
        inc_exp = '{16'd10, 16'd20, 16'd25, 16'd25};
        dec_exp = '{16'd15, 16'd5, 16'd0, 16'd0};
        press_ok();
        for (int i = 0; i < 4; i++) begin
            press_inc();
            check_eq($sformatf("t2_inc%0d", i), 32'(bus.bet_amount), 32'(inc_exp[i]));
        end
        for (int i = 0; i < 4; i++) begin
            press_dec();
            check_eq($sformatf("t2_dec%0d", i), 32'(bus.bet_amount), 32'(dec_exp[i]));
        end

        // Zero bet is rejected for exactly 5 cycles
        press_ok(); press_ok();
        check_eq("t3_confirm", 32'(bus.state), 3);
        tick(1);
        check_eq("t3_reject", 32'(bus.state), 4);
        press_ok();
        tick(3);
        check_eq("t3_reject_last", 32'(bus.state), 4);
        tick(1);
        check_eq("t3_back_amount", 32'(bus.state), 1);
        check_eq("t3_amt_zero", 32'(bus.bet_amount), 0);

        // Bet above a balance that dropped after selection is rejected and cleared
        press_inc(); press_inc();
        check_eq("t3b_amt20", 32'(bus.bet_amount), 20);
        bus.current_money = 16'd15;
        press_ok(); press_ok();
        tick(1);
        check_eq("t3b_reject", 32'(bus.state), 4);
        tick(5);
        check_eq("t3b_back_amount", 32'(bus.state), 1);
        check_eq("t3b_amt_zero", 32'(bus.bet_amount), 0);

        // Count wrap, back keeps amount, ok beats back
        bus.current_money = 16'd100;
        press_inc();
        press_ok();
        press_dec();
        check_eq("t6_cnt_wrap_dn", 32'(bus.bet_count), 4);
        press_inc();
        check_eq("t6_cnt_wrap_up", 32'(bus.bet_count), 1);
        press_back();
        check_eq("t6_back_state", 32'(bus.state), 1);
        check_eq("t6_back_amt", 32'(bus.bet_amount), 10);
        press_ok();
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t6_ok_over_back", 32'(bus.state), 3);
        tick(1);
        press_back();
        check_eq("t6_spin_no_cancel", 32'(bus.state), 5);

        // Losing round, balance reaches zero -> GAME_OVER
        bus.win_in = 1'b0;
        press_ok();
        tick(1);
        check_eq("t5_win_cleared", 32'(bus.win_flag), 0);
        bus.current_money = 16'd0;
        tick(1);
        tick(1);
        check_eq("t5_show", 32'(bus.state), 10);
        tick(4);
        check_eq("t5_game_over", 32'(bus.state), 11);
        press_ok(); press_back(); press_inc(); press_dec();
        check_eq("t5_game_over_held", 32'(bus.state), 11);
        rst_n = 1'b0;
        #1;
        check_eq("t5_reset_exit", 32'(bus.state), 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Asynchronous reset in the middle of UPDATE_MONEY
        bus.current_money = 16'd100;
        bus.win_in = 1'b1;
        press_ok(); press_inc(); press_inc(); press_ok();
        press_ok();
        tick(1);
        press_ok();
        tick(1);
        check_eq("t7_in_update", 32'(bus.state), 9);
        check_eq("t7_win_set", 32'(bus.win_flag), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("t7_async");
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check_eq("t7_after_release", 32'(bus.state), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Main game FSM for one betting round: gathers bet amount and bet count from debounced button pulses, validates the bet against the current balance, runs the spin/stop/result sequence, and drives the 4-bit `state` code consumed by the balance-update and display logic. It owns `bet_amount`, `bet_count` and the latched `win_flag`. It also holds the update phase long enough for the balance to settle before showing the result.

## Interface
- `AMT_STEP`, 10: bet-amount increment/decrement per button pulse.
- `REJECT_CYCLES`, 50_000_000: dwell time in S_REJECT.
- `SHOW_CYCLES`, 100_000_000: dwell time in S_SHOW_RESULT.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_ok`  in  1  one-cycle pulse: confirm / advance / stop.
- `btn_back`  in  1  one-cycle pulse: return to previous input step.
- `btn_inc`  in  1  one-cycle pulse: increase selected value.
- `btn_dec`  in  1  one-cycle pulse: decrease selected value.
- `win_in`  in  1  judge result, valid while `state`=S_STOP_RESULT.
- `current_money`  in  16  balance from the balance-update block.
- `state`  out  4  FSM state code.
- `bet_amount`  out  16  selected bet.
- `bet_count`  out  3  selected count, 1..4.
- `win_flag`  out  1  win result latched for this round.
- `spin_en`  out  1  reel animation enable.

## Operation
- State codes are fixed and shared with downstream blocks:
  - 0 S_IDLE
  - 1 S_INPUT_AMOUNT
  - 2 S_INPUT_COUNT
  - 3 S_CONFIRM
  - 4 S_REJECT
  - 5 S_SPIN
  - 8 S_STOP_RESULT
  - 9 S_UPDATE_MONEY
  - 10 S_SHOW_RESULT
  - 11 S_GAME_OVER
  - Codes 6, 7, 12–15 are unused; if reached, go to S_IDLE on the next cycle.
- Button priority within one cycle: `btn_ok` > `btn_back` > `btn_inc` > `btn_dec`. Only the highest-priority pulse acts; the others are ignored.
- S_IDLE:
  - `btn_ok` → S_INPUT_AMOUNT.
  - On entry from S_SHOW_RESULT: `bet_amount`←0 and `bet_count`←1.
- S_INPUT_AMOUNT:
  - `btn_inc`: `bet_amount`←min(`bet_amount`+AMT_STEP, `current_money`), computed at 17 bits so it cannot wrap.
  - `btn_dec`: `bet_amount`←max(`bet_amount`−AMT_STEP, 0), with no underflow.
  - `btn_ok` → S_INPUT_COUNT.
  - `btn_back` → S_IDLE.
- S_INPUT_COUNT:
  - `btn_inc` wraps 4→1; `btn_dec` wraps 1→4.
  - `btn_ok` → S_CONFIRM.
  - `btn_back` → S_INPUT_AMOUNT, keeping `bet_amount`.
- S_CONFIRM (one cycle, no button effect):
  - if `bet_amount`==0 or `bet_amount`>`current_money` → S_REJECT;
  - otherwise → S_SPIN.
- S_REJECT: stays REJECT_CYCLES cycles, then → S_INPUT_AMOUNT with `bet_amount`←0. Buttons are ignored.
- S_SPIN: `spin_en`=1. `btn_ok` → S_STOP_RESULT. `btn_back` is ignored, so a bet cannot be cancelled after confirmation.
- S_STOP_RESULT (one cycle): `win_flag`←`win_in` → S_UPDATE_MONEY.
- S_UPDATE_MONEY: held exactly 2 cycles, then → S_SHOW_RESULT. The balance block acts on the entry edge; the second cycle lets `current_money` settle.
- S_SHOW_RESULT: stays SHOW_CYCLES cycles, then:
  - `current_money`==0 → S_GAME_OVER;
  - otherwise → S_IDLE.
- S_GAME_OVER: terminal. Only `rst_n` exits it.
- `bet_amount` and `bet_count` are constant from S_CONFIRM through S_SHOW_RESULT.
- One shared dwell counter of 32 bits. It clears on every state change and counts only in S_REJECT and S_SHOW_RESULT. Exit happens when counter == N−1, giving exactly N cycles in the state.

## Timing
- Reset (`rst_n`=0, asynchronous) values:
  - `state`=0, `bet_amount`=0, `bet_count`=1, `win_flag`=0, `spin_en`=0, counter=0.
- When `rst_n` is asserted mid-round, all outputs return to reset values immediately, with no clock needed. Release is synchronous to the next `clk` rising edge.
- All outputs are registered. A button pulse sampled at edge k appears in `state`, `bet_amount` or `bet_count` after edge k.
- `spin_en` is registered and decoded from the next state, so it is high exactly while `state`=5.
- `win_flag` updates at the edge that leaves S_STOP_RESULT. It holds until the next S_STOP_RESULT or reset.
- Round latency from `btn_ok` in S_INPUT_COUNT to reaching S_SPIN: 2 edges (CONFIRM, then SPIN).
- Latency from `btn_ok` in S_SPIN to reaching S_SHOW_RESULT: 4 edges (STOP_RESULT 1 + UPDATE_MONEY 2 + 1).

## Test plan
- Reset, `current_money`=100; ok, inc×3, ok, inc, ok → `state` passes 1, 2, 3, 5; `bet_amount`=30, `bet_count`=2, `spin_en`=1.
- `current_money`=25, inc×4 in S_INPUT_AMOUNT → `bet_amount` goes 10, 20, 25, 25 (saturates); dec×4 → 15, 5, 0, 0.
- `bet_amount`=0 confirmed → S_REJECT for exactly REJECT_CYCLES (override to 5 in the bench), then S_INPUT_AMOUNT with `bet_amount`=0.
- In S_SPIN, `btn_ok` with `win_in`=1 → `state` 8, 9, 9, 10; `win_flag`=1; after SHOW_CYCLES (override 4) with `current_money`=130 → S_IDLE, `bet_amount`=0, `bet_count`=1.
- Losing round with `current_money` driven to 0 during S_UPDATE_MONEY → S_SHOW_RESULT, then S_GAME_OVER; all buttons ignored afterwards; `rst_n` pulse → `state`=0.
- `btn_ok` and `btn_back` in the same cycle in S_INPUT_COUNT → S_CONFIRM. Asserting `rst_n`=0 mid-S_UPDATE_MONEY → outputs reset immediately, before the next clock edge.
